// File: rtl/freelist_pkg.sv
// Shared definitions for the freelist id allocator and the linked descriptor queue built on it.
package freelist_pkg;

  localparam int unsigned fl_dwidth = 8;
  localparam int unsigned fl_depth  = 1 << fl_dwidth;

  typedef enum logic [1:0] {
    EnqIdle,
    EnqReq,
    EnqWait,
    EnqLink
  } enq_state_e;

  typedef enum logic [1:0] {
    DeqIdle,
    DeqReq,
    DeqWait
  } deq_state_e;

  function automatic int unsigned depth_of(input int unsigned dw);
    return 32'd1 << dw;
  endfunction

endpackage

// File: rtl/lq_linkmem.sv
// Payload and next-pointer storage, one entry per slot id; async read at the queue head.
module lq_linkmem
  import freelist_pkg::*;
#(
  parameter int unsigned dwidth = fl_dwidth,
  parameter int unsigned pwidth = 16
) (
  input  logic              clk,
  input  logic              data_we,
  input  logic [dwidth-1:0] data_waddr,
  input  logic [pwidth-1:0] data_wdata,
  input  logic              next_we,
  input  logic [dwidth-1:0] next_waddr,
  input  logic [dwidth-1:0] next_wdata,
  input  logic [dwidth-1:0] raddr,
  output logic [pwidth-1:0] data_rdata,
  output logic [dwidth-1:0] next_rdata
);

  localparam int unsigned depth = depth_of(dwidth);

  logic [pwidth-1:0] data_mem [depth];
  logic [dwidth-1:0] next_mem [depth];

  // Contents are meaningful only once linked, so no reset is needed.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (next_we) next_mem[next_waddr] <= next_wdata;
  end

  assign data_rdata = data_mem[raddr];
  assign next_rdata = next_mem[raddr];

endmodule

// File: rtl/linked_queue.sv
// FIFO of payloads stored at freelist-allocated slot ids and chained as a singly-linked list.
module linked_queue
  import freelist_pkg::*;
#(
  parameter int unsigned dwidth = fl_dwidth,
  parameter int unsigned pwidth = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  input  logic [pwidth-1:0] enq_data,
  output logic              enq_ready,
  output logic              deq_valid,
  output logic [pwidth-1:0] deq_data,
  output logic [dwidth-1:0] deq_id,
  input  logic              deq_ready,
  output logic [dwidth:0]   count,
  input  logic              fl_init_done,
  output logic              fl_alloc_req,
  input  logic [dwidth-1:0] fl_alloc_id,
  input  logic              fl_alloc_ack,
  output logic              fl_dealloc_req,
  output logic [dwidth-1:0] fl_dealloc_id,
  input  logic              fl_dealloc_ack
);

  enq_state_e        enq_state;
  deq_state_e        deq_state;
  logic [pwidth-1:0] enq_payload;
  logic [dwidth-1:0] link_id;
  logic [dwidth-1:0] head;
  logic [dwidth-1:0] tail;
  logic [dwidth:0]   count_q;
  logic [dwidth-1:0] dealloc_id_q;
  logic [pwidth-1:0] head_data;
  logic [dwidth-1:0] head_next;

  logic            enq_fire;
  logic            deq_fire;
  logic            link;
  logic            link_as_head;
  logic [dwidth:0] count_after_deq;

  assign enq_ready = (enq_state == EnqIdle) && fl_init_done;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_valid = (deq_state == DeqIdle) && (count_q != '0);
  assign deq_fire  = deq_valid && deq_ready;
  assign link      = (enq_state == EnqLink);

  // A link that lands while the last entry leaves becomes the new head; next_mem[tail] is stale.
  assign count_after_deq = count_q - {{dwidth{1'b0}}, deq_fire};
  assign link_as_head    = link && (count_after_deq == '0);

  assign fl_alloc_req   = (enq_state == EnqReq);
  assign fl_dealloc_req = (deq_state == DeqReq);
  assign fl_dealloc_id  = dealloc_id_q;
  assign deq_id         = head;
  assign deq_data       = deq_valid ? head_data : '0;
  assign count          = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      enq_state   <= EnqIdle;
      enq_payload <= '0;
      link_id     <= '0;
    end else begin
      case (enq_state)
        EnqIdle: begin
          if (enq_fire) begin
            enq_payload <= enq_data;
            enq_state   <= EnqReq;
          end
        end
        EnqReq:  enq_state <= EnqWait;
        EnqWait: begin
          if (fl_alloc_ack) begin
            link_id   <= fl_alloc_id;
            enq_state <= EnqLink;
          end
        end
        EnqLink: enq_state <= EnqIdle;
        default: enq_state <= EnqIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deq_state    <= DeqIdle;
      dealloc_id_q <= '0;
    end else begin
      case (deq_state)
        DeqIdle: begin
          if (deq_fire) begin
            dealloc_id_q <= head;
            deq_state    <= DeqReq;
          end
        end
        DeqReq:  deq_state <= DeqWait;
        DeqWait: if (fl_dealloc_ack) deq_state <= DeqIdle;
        default: deq_state <= DeqIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (deq_fire) head <= head_next;
      if (link_as_head) head <= link_id;
      if (link) tail <= link_id;
      count_q <= count_q + {{dwidth{1'b0}}, link} - {{dwidth{1'b0}}, deq_fire};
    end
  end

  lq_linkmem #(
    .dwidth(dwidth),
    .pwidth(pwidth)
  ) u_linkmem (
    .clk        (clk),
    .data_we    (link),
    .data_waddr (link_id),
    .data_wdata (enq_payload),
    .next_we    (link && !link_as_head),
    .next_waddr (tail),
    .next_wdata (link_id),
    .raddr      (head),
    .data_rdata (head_data),
    .next_rdata (head_next)
  );

endmodule
